hazard_stall_ctrl: RTL

- Pipeline control block at the F/D -> D/X boundary, directly upstream of the ALU-input bypass logic.
- Decides which cases bypassing cannot resolve: load-use hazards and multi-cycle mult/div.
- Stalls PC/FD and inserts bubbles into DX or XM.
- Sequences the multdiv unit: start pulse, busy hold, result writeback, timeout.

---
 rtl/hazard_stall_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall detection and mult/div sequencing (IDLE -> BUSY -> WB) at the F/D -> D/X boundary.
// Optional macro STALL_PERF_EN adds a free-running stall_cycles counter output.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        branch_flush,
  input  logic        md_result_rdy,
  input  logic        md_exception,
  output logic        stall,
  output logic        dx_bubble,
  output logic        dx_hold,
  output logic        xm_bubble,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        md_busy,
  output logic        md_wb_sel,
  output logic        md_ovf_out,
  output logic        md_timeout,
  output logic [1:0]  fsm_state
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BEX   = 5'b10110;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             exc_q, exc_next;

  logic [4:0] fd_op, dx_op, dx_rd, src_a, src_b;
  logic       src_b_vld, dx_mul, dx_div, load_use;
  logic       unused_bits;

  assign unused_bits = ^{fd_ir[11:7], fd_ir[1:0], dx_ir[21:7], dx_ir[1:0]};

  assign fd_op  = fd_ir[31:27];
  assign dx_op  = dx_ir[31:27];
  assign dx_rd  = dx_ir[26:22];
  assign src_a  = fd_ir[21:17];
  assign dx_mul = (dx_op == OP_RTYPE) && (dx_ir[6:2] == ALU_MUL);
  assign dx_div = (dx_op == OP_RTYPE) && (dx_ir[6:2] == ALU_DIV);

  // sw data is not a source here: the W->M bypass already covers it.
  always_comb begin
    src_b     = 5'd0;
    src_b_vld = 1'b0;
    if (fd_op == OP_RTYPE) begin
      src_b     = fd_ir[16:12];
      src_b_vld = 1'b1;
    end else if (fd_op == OP_BEX) begin
      src_b     = 5'd30;
      src_b_vld = 1'b1;
    end else if (fd_op == OP_BNE || fd_op == OP_BLT || fd_op == OP_JR) begin
      src_b     = fd_ir[26:22];
      src_b_vld = 1'b1;
    end
  end

  assign load_use = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                    ((src_a == dx_rd) || (src_b_vld && (src_b == dx_rd)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      exc_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      exc_q <= exc_next;
    end
  end

  // Outputs are forced low while reset is held so in-flight pulses drop at once.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    exc_next     = exc_q;
    stall        = 1'b0;
    dx_bubble    = 1'b0;
    dx_hold      = 1'b0;
    xm_bubble    = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    md_busy      = 1'b0;
    md_wb_sel    = 1'b0;
    md_ovf_out   = 1'b0;
    md_timeout   = 1'b0;
    if (reset) begin
      case (state)
        S_IDLE: begin
          if (!branch_flush && (dx_mul || dx_div)) begin
            md_ctrl_mult = dx_mul;
            md_ctrl_div  = dx_div;
            stall        = 1'b1;
            dx_hold      = 1'b1;
            xm_bubble    = 1'b1;
            cnt_next     = '0;
            state_next   = S_BUSY;
          end else if (load_use) begin
            stall     = 1'b1;
            dx_bubble = 1'b1;
          end
        end
        S_BUSY: begin
          md_busy   = 1'b1;
          stall     = 1'b1;
          xm_bubble = 1'b1;
          cnt_next  = cnt + CNT_W'(1);
          if (md_result_rdy) begin
            dx_hold    = 1'b1;
            exc_next   = md_exception;
            state_next = S_WB;
          end else if (cnt == CNT_W'(MD_TIMEOUT - 1)) begin
            // Abandon the op: the bubble replaces the held mul/div in D/X.
            md_timeout = 1'b1;
            dx_bubble  = 1'b1;
            cnt_next   = '0;
            state_next = S_IDLE;
          end else begin
            dx_hold = 1'b1;
          end
        end
        S_WB: begin
          md_wb_sel  = 1'b1;
          md_ovf_out = exc_q;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign fsm_state = state;

`ifdef STALL_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stall_cycles <= 32'd0;
    else if (stall) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
